divide_arbiter: RTL and testbench
=================================

Name: divide_arbiter

Overview:
- Shares one divide_top instance among N_REQ requesters.
- Pulls dividend/divisor pairs from per-requester FWFT FIFO interfaces using round-robin arbitration, and stages each pair toward the divider's FIFO-style input.
- Records the requester ID of every issued operation in an internal tag FIFO.
- Routes quotients popped from the divider's output FIFO back to the originating requester, in issue order.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- D_BITS, 32, data width; must match the divider.
- MAX_OUTSTANDING, 16, tag FIFO depth, i.e. maximum operations in flight inside the divider. Power of 2.
- ID_W, $clog2(N_REQ), requester ID width.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- req_empty, input, N_REQ, per-requester FIFO empty.
- req_rd_en, output, N_REQ, per-requester pop, one-hot or zero.
- req_dividend, input, N_REQ*D_BITS, signed dividends; requester i occupies bits [i*D_BITS +: D_BITS].
- req_divisor, input, N_REQ*D_BITS, signed divisors, same packing.
- div_dividend, output, D_BITS, staged dividend to the divider.
- div_divisor, output, D_BITS, staged divisor to the divider.
- div_in_empty, output, 1, low when the staging register holds an operation.
- div_in_rd_en, input, 1, divider consumes the staged operation.
- div_out_empty, input, 1, divider result FIFO empty.
- div_out_rd_en, output, 1, pop divider result.
- div_out_dout, input, D_BITS, divider quotient (FWFT).
- res_valid, output, N_REQ, one-hot: result held for requester i.
- res_ready, input, N_REQ, requester i accepts its result.
- res_quotient, output, D_BITS, quotient; shared bus, qualified by res_valid.
- outstanding, output, $clog2(MAX_OUTSTANDING)+1, operations issued but not yet delivered.
- tag_err, output, 1, sticky: a divider result arrived with no tag.

Behaviour:
- Reset (reset=0, asynchronous):
  - Cleared: stage_valid, tag FIFO, output register, outstanding, tag_err.
  - rr_ptr is set to N_REQ-1, so requester 0 has first priority.
  - All outputs are 0, except div_in_empty=1.
  - Reset mid-operation drops everything in flight. Results still in the divider are the system's responsibility; the divider is reset by the same signal.
- All input interfaces are FWFT: data is valid whenever empty=0, and is consumed on the edge where rd_en=1.
- Issue:
  - can_load = (!stage_valid | div_in_rd_en) & !tag_full.
  - When can_load is true, grant the first i, scanning from rr_ptr+1 modulo N_REQ, with req_empty[i]=0.
  - The grant is combinational: assert req_rd_en[i]. On the same edge, capture the pair into the staging register, set stage_valid, push i into the tag FIFO, and set rr_ptr=i.
  - No grant: rr_ptr is unchanged.
- Staging: div_in_empty = !stage_valid. div_in_rd_en with stage_valid clears stage_valid unless it is reloaded on the same edge. div_in_rd_en while the stage is empty is ignored.
- Tag FIFO: depth MAX_OUTSTANDING. tag_full counts staged operations plus operations in the divider plus the held result; it equals outstanding==MAX_OUTSTANDING. This guarantees every divider result has a tag.
- Return path:
  - out_free = !res_any_valid | res_ready[res_id].
  - When out_free & !div_out_empty & !tag_empty: assert div_out_rd_en, pop the tag, load res_quotient=div_out_dout and res_id=tag, and set res_valid = one-hot(tag).
  - Otherwise, when res_ready[res_id] is asserted, clear res_valid.
  - A held result is stable until accepted. res_ready of non-selected requesters is ignored.
- Untagged result: when !div_out_empty & tag_empty & out_free, pop and discard the result, and set tag_err. tag_err is cleared only by reset.
- outstanding: +1 on issue, -1 on result acceptance (res_valid & res_ready). A simultaneous issue and acceptance leaves it unchanged. It never exceeds MAX_OUTSTANDING.
- Latency:
  - Requester pop to div_in_empty=0: 1 cycle.
  - Divider pop to res_valid: 1 cycle.
  - Throughput: 1 operation/cycle when the divider and requesters keep up.
- Results return in issue order. Per-requester ordering is therefore preserved.

Test Plan:
- Single request: requester 2 pushes 100/7 (Q10 values 102400/7168), divider modelled as divide_top -> req_rd_en=0100 for one cycle; res_valid=0100 with quotient 14.285 in Q10 (14628); outstanding returns 0.
- All four requesters continuously non-empty, divider always ready -> grants cycle 0,1,2,3,0,... with exactly one req_rd_en per cycle; each res_valid routes to the issuing ID.
- Back-pressure: res_ready=0 for 20 cycles with MAX_OUTSTANDING=4 -> exactly 4 issues, then req_rd_en stays 0 and outstanding=4; releasing res_ready resumes issue on the next cycle.
- Divider stall: div_in_rd_en=0 -> stage holds 5/3 unchanged and div_in_empty=0; no second grant occurs until div_in_rd_en pulses.
- Injected spurious div_out_empty=0 with outstanding=0 -> div_out_rd_en=1, result dropped, tag_err=1 and held through later traffic.
- Reset asserted with 3 operations outstanding -> all outputs cleared asynchronously; after release, requester 0 is granted first.

Source files
------------

// File: rtl/divide_arbiter.sv
// Round-robin front end that shares one FIFO-style divider among N_REQ requesters.
// A tag FIFO records who issued each operation, so quotients are routed back in issue order.
module divide_arbiter #(
  parameter int N_REQ           = 4,
  parameter int D_BITS          = 32,
  parameter int MAX_OUTSTANDING = 16,
  parameter int ID_W            = $clog2(N_REQ)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_REQ-1:0]                  req_empty,
  output logic [N_REQ-1:0]                  req_rd_en,
  input  logic [N_REQ*D_BITS-1:0]           req_dividend,
  input  logic [N_REQ*D_BITS-1:0]           req_divisor,
  output logic [D_BITS-1:0]                 div_dividend,
  output logic [D_BITS-1:0]                 div_divisor,
  output logic                              div_in_empty,
  input  logic                              div_in_rd_en,
  input  logic                              div_out_empty,
  output logic                              div_out_rd_en,
  input  logic [D_BITS-1:0]                 div_out_dout,
  output logic [N_REQ-1:0]                  res_valid,
  input  logic [N_REQ-1:0]                  res_ready,
  output logic [D_BITS-1:0]                 res_quotient,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              tag_err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int OUT_W = PTR_W + 1;

  logic              stage_valid;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic              grant_found;
  logic              can_load;
  logic              issue;
  logic [ID_W-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [PTR_W:0]    tag_wr_ptr;
  logic [PTR_W:0]    tag_rd_ptr;
  logic [ID_W-1:0]   tag_head;
  logic              tag_empty;
  logic              tag_full;
  logic [ID_W-1:0]   res_id;
  logic              res_any_valid;
  logic              res_accept;
  logic              out_free;
  logic              res_load;
  logic              res_drop;
  logic [D_BITS-1:0] grant_dividend;
  logic [D_BITS-1:0] grant_divisor;

  // The tag FIFO can never hold more entries than outstanding, so this bound also keeps it from overflowing.
  assign tag_full  = (outstanding == OUT_W'(MAX_OUTSTANDING));
  assign tag_empty = (tag_wr_ptr == tag_rd_ptr);
  assign tag_head  = tag_mem[tag_rd_ptr[PTR_W-1:0]];
  assign can_load  = (!stage_valid || div_in_rd_en) && !tag_full;

  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx  = (int'(rr_ptr) + 1 + k) % N_REQ;
      cand = ID_W'(idx);
      if (!grant_found && !req_empty[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign issue          = can_load && grant_found;
  assign grant_dividend = req_dividend[int'(grant_id)*D_BITS +: D_BITS];
  assign grant_divisor  = req_divisor[int'(grant_id)*D_BITS +: D_BITS];
  // Pops are masked while in reset so no requester loses data the staging register never captured.
  assign req_rd_en      = (issue && reset) ? (N_REQ'(1) << grant_id) : '0;
  assign div_in_empty   = !stage_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_valid  <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else if (issue) begin
      stage_valid  <= 1'b1;
      div_dividend <= grant_dividend;
      div_divisor  <= grant_divisor;
    end else if (div_in_rd_en) begin
      stage_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= ID_W'(N_REQ - 1);
    end else if (issue) begin
      rr_ptr <= grant_id;
    end
  end

  always_ff @(posedge clock) begin
    if (issue) begin
      tag_mem[tag_wr_ptr[PTR_W-1:0]] <= grant_id;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else begin
      if (issue) begin
        tag_wr_ptr <= tag_wr_ptr + 1'b1;
      end
      if (res_load) begin
        tag_rd_ptr <= tag_rd_ptr + 1'b1;
      end
    end
  end

  assign res_any_valid = |res_valid;
  assign res_accept    = res_any_valid && res_ready[res_id];
  assign out_free      = !res_any_valid || res_ready[res_id];
  assign res_load      = out_free && !div_out_empty && !tag_empty;
  assign res_drop      = out_free && !div_out_empty && tag_empty;
  assign div_out_rd_en = reset && (res_load || res_drop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_valid    <= '0;
      res_id       <= '0;
      res_quotient <= '0;
    end else if (res_load) begin
      res_valid    <= N_REQ'(1) << tag_head;
      res_id       <= tag_head;
      res_quotient <= div_out_dout;
    end else if (res_accept) begin
      res_valid    <= '0;
    end
  end

  // A result with no tag means the divider and this block disagree on what is in flight; remember it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_err <= 1'b0;
    end else if (res_drop) begin
      tag_err <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({issue, res_accept})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_arbiter.sv
// Bench for divide_arbiter: FWFT requester queues, a Q10 divider model and a per-requester scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_divide_arbiter;

  localparam int N_REQ   = 4;
  localparam int D_BITS  = 32;
  localparam int MAX_OUT = 4;
  localparam int OUT_W   = $clog2(MAX_OUT) + 1;

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic [N_REQ-1:0]          req_empty;
  logic [N_REQ-1:0]          req_rd_en;
  logic [N_REQ*D_BITS-1:0]   req_dividend;
  logic [N_REQ*D_BITS-1:0]   req_divisor;
  logic [D_BITS-1:0]         div_dividend;
  logic [D_BITS-1:0]         div_divisor;
  logic                      div_in_empty;
  logic                      div_in_rd_en;
  logic                      div_out_empty;
  logic                      div_out_rd_en;
  logic [D_BITS-1:0]         div_out_dout;
  logic [N_REQ-1:0]          res_valid;
  logic [N_REQ-1:0]          res_ready;
  logic [D_BITS-1:0]         res_quotient;
  logic [OUT_W-1:0]          outstanding;
  logic                      tag_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] rq_a  [N_REQ][$];
  logic [31:0] rq_b  [N_REQ][$];
  logic [31:0] exp_q [N_REQ][$];
  logic [31:0] div_q [$];

  logic             div_ready   = 1'b1;
  logic             spurious    = 1'b0;
  logic [N_REQ-1:0] res_ready_r = '1;
  logic             model_has   = 1'b0;
  logic [31:0]      model_head  = '0;

  logic [N_REQ-1:0] pop_req  = '0;
  logic             take_in  = 1'b0;
  logic [31:0]      take_a   = '0;
  logic [31:0]      take_b   = '0;
  logic             pop_out  = 1'b0;

  assign div_in_rd_en  = div_ready;
  assign res_ready     = res_ready_r;
  assign div_out_empty = !(model_has || spurious);
  assign div_out_dout  = model_has ? model_head : 32'hDEAD_BEEF;

  divide_arbiter #(
    .N_REQ(N_REQ), .D_BITS(D_BITS), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_empty(req_empty), .req_rd_en(req_rd_en),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_in_empty(div_in_empty), .div_in_rd_en(div_in_rd_en),
    .div_out_empty(div_out_empty), .div_out_rd_en(div_out_rd_en),
    .div_out_dout(div_out_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_quotient(res_quotient),
    .outstanding(outstanding), .tag_err(tag_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] q10_div(input logic [31:0] a, input logic [31:0] b);
    longint num;
    longint den;
    num = longint'($signed(a)) * 64'sd1024;
    den = longint'($signed(b));
    return 32'(num / den);
  endfunction

  function automatic void refresh();
    for (int i = 0; i < N_REQ; i++) begin
      req_empty[i] = (rq_a[i].size() == 0);
      req_dividend[i*D_BITS +: D_BITS] = (rq_a[i].size() != 0) ? rq_a[i][0] : 32'd0;
      req_divisor[i*D_BITS +: D_BITS]  = (rq_b[i].size() != 0) ? rq_b[i][0] : 32'd0;
    end
    model_has  = (div_q.size() != 0);
    model_head = model_has ? div_q[0] : 32'd0;
  endfunction

  function automatic bit all_empty();
    bit e;
    e = (div_q.size() == 0);
    for (int i = 0; i < N_REQ; i++) begin
      if (exp_q[i].size() != 0 || rq_a[i].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  function automatic void clear_models();
    for (int i = 0; i < N_REQ; i++) begin
      rq_a[i].delete();
      rq_b[i].delete();
      exp_q[i].delete();
    end
    div_q.delete();
    refresh();
  endfunction

  function automatic void push_req(input int id, input logic [31:0] a, input logic [31:0] b);
    rq_a[id].push_back(a);
    rq_b[id].push_back(b);
    exp_q[id].push_back(q10_div(a, b));
    refresh();
  endfunction

  // Sample handshakes on the falling edge; accepted results are scored against the requester's queue.
  always @(negedge clock) begin
    pop_req = req_rd_en;
    take_in = div_in_rd_en && !div_in_empty;
    take_a  = div_dividend;
    take_b  = div_divisor;
    pop_out = div_out_rd_en && !div_out_empty;
    if (reset && ((res_valid & res_ready_r) != '0)) begin
      int id;
      id = 0;
      for (int i = 0; i < N_REQ; i++) if (res_valid[i]) id = i;
      tests_run++;
      if ($countones(res_valid) != 1) begin
        tests_failed++;
        $display("[TB] FAIL res_onehot: got %b required one-hot", res_valid);
      end
      tests_run++;
      if (exp_q[id].size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL res_route: got result %0d for requester %0d required none pending", res_quotient, id);
      end else begin
        logic [31:0] e;
        e = exp_q[id].pop_front();
        if (res_quotient !== e) begin
          tests_failed++;
          $display("[TB] FAIL res_quotient[%0d]: got %0d required %0d", id, $signed(res_quotient), $signed(e));
        end
      end
    end
  end

  always @(posedge clock) begin
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (pop_req[i] && rq_a[i].size() != 0) begin
        void'(rq_a[i].pop_front());
        void'(rq_b[i].pop_front());
      end
    end
    if (pop_out && div_q.size() != 0) void'(div_q.pop_front());
    if (take_in) div_q.push_back(q10_div(take_a, take_b));
    pop_req = '0;
    take_in = 1'b0;
    pop_out = 1'b0;
    refresh();
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    spurious = 1'b0;
    clear_models();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(all_empty() && outstanding === '0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    tests_run++;
    if (!(all_empty() && outstanding === '0)) begin
      tests_failed++;
      $display("[TB] FAIL %s_drain: outstanding %0d required 0 with all results delivered", name, outstanding);
    end
  endtask

  task automatic wait_grant(output logic [N_REQ-1:0] g);
    int n;
    n = 0;
    g = '0;
    while (n < 20) begin
      @(negedge clock);
      if (req_rd_en != '0) begin
        g = req_rd_en;
        break;
      end
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    tests_run++;
    if ({req_rd_en, div_in_empty, div_out_rd_en, res_valid} !== {4'b0, 1'b1, 1'b0, 4'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got rd_en=%b in_empty=%b out_rd=%b res_valid=%b required 0000 1 0 0000",
               req_rd_en, div_in_empty, div_out_rd_en, res_valid);
    end
    tests_run++;
    if ({res_quotient, div_dividend, div_divisor, outstanding, tag_err} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got quot=%0d dvd=%0d dvs=%0d outst=%0d tag_err=%b required all 0",
               res_quotient, div_dividend, div_divisor, outstanding, tag_err);
    end
    @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] g;
    int n;
    tick();
    push_req(2, 32'd102400, 32'd7168);
    wait_grant(g);
    tests_run++;
    if (g !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL single_grant: got %b required 0100", g);
    end
    @(negedge clock);
    tests_run++;
    if ({req_rd_en, div_in_empty, div_dividend, div_divisor} !== {4'b0, 1'b0, 32'd102400, 32'd7168}) begin
      tests_failed++;
      $display("[TB] FAIL single_stage: got rd_en=%b in_empty=%b %0d/%0d required 0000 0 102400/7168",
               req_rd_en, div_in_empty, div_dividend, div_divisor);
    end
    n = 0;
    while (res_valid == '0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    tests_run++;
    if (res_valid !== 4'b0100 || res_quotient !== 32'd14628) begin
      tests_failed++;
      $display("[TB] FAIL single_result: got valid=%b quot=%0d required 0100 14628", res_valid, res_quotient);
    end
    wait_drain("single");
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] g;
    do_reset();
    tick();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < N_REQ; i++) begin
        int a;
        a = ((i + 1) * 3000 + rep * 517) * ((i == 3) ? -1 : 1);
        push_req(i, 32'(a), 32'(i + 2 + rep));
      end
    end
    wait_grant(g);
    for (int k = 0; k < 12; k++) begin
      logic [N_REQ-1:0] e;
      if (k != 0) begin
        @(negedge clock);
        g = req_rd_en;
      end
      e = N_REQ'(1) << (k % N_REQ);
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant[%0d]: got %b required %b", k, g, e);
      end
    end
    @(negedge clock);
    tests_run++;
    if (req_rd_en !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rr_idle: got %b required 0000", req_rd_en);
    end
    wait_drain("rr");
  endtask

  task automatic test_back_pressure();
    int grants;
    do_reset();
    tick();
    res_ready_r = '0;
    for (int i = 0; i < 3; i++) begin
      push_req(i, 32'(1000 * (i + 1)), 32'd3);
      push_req(i, 32'(-700 * (i + 1)), 32'd5);
    end
    grants = 0;
    repeat (20) begin
      @(negedge clock);
      if (req_rd_en != '0) grants++;
    end
    tests_run++;
    if (grants !== 4 || outstanding !== OUT_W'(4) || req_rd_en !== '0) begin
      tests_failed++;
      $display("[TB] FAIL bp_limit: got grants=%0d outstanding=%0d rd_en=%b required 4 4 0000",
               grants, outstanding, req_rd_en);
    end
    tests_run++;
    if (res_valid !== 4'b0001 || res_quotient !== exp_q[0][0]) begin
      tests_failed++;
      $display("[TB] FAIL bp_hold: got valid=%b quot=%0d required 0001 %0d", res_valid, res_quotient, exp_q[0][0]);
    end
    tick();
    res_ready_r = '1;
    repeat (2) @(negedge clock);
    tests_run++;
    if (req_rd_en !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL bp_resume: got %b required 0010", req_rd_en);
    end
    wait_drain("bp");
  endtask

  task automatic test_stall();
    logic [N_REQ-1:0] g;
    do_reset();
    tick();
    div_ready = 1'b0;
    push_req(1, 32'd5, 32'd3);
    push_req(1, 32'd7, 32'd2);
    wait_grant(g);
    tests_run++;
    if (g !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL stall_grant: got %b required 0010", g);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      tests_run++;
      if ({div_in_empty, req_rd_en, div_dividend, div_divisor} !== {1'b0, 4'b0, 32'd5, 32'd3}) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold[%0d]: got in_empty=%b rd_en=%b %0d/%0d required 0 0000 5/3",
                 k, div_in_empty, req_rd_en, div_dividend, div_divisor);
      end
    end
    tick();
    div_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if (req_rd_en !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL stall_pulse_grant: got %b required 0010", req_rd_en);
    end
    tick();
    div_ready = 1'b0;
    @(negedge clock);
    tests_run++;
    if (div_in_empty !== 1'b0 || div_dividend !== 32'd7 || div_divisor !== 32'd2) begin
      tests_failed++;
      $display("[TB] FAIL stall_reload: got in_empty=%b %0d/%0d required 0 7/2", div_in_empty, div_dividend, div_divisor);
    end
    tick();
    div_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_spurious();
    tick();
    spurious = 1'b1;
    @(negedge clock);
    tests_run++;
    if (div_out_rd_en !== 1'b1 || tag_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL spur_pop: got out_rd=%b tag_err=%b required 1 0", div_out_rd_en, tag_err);
    end
    tick();
    spurious = 1'b0;
    @(negedge clock);
    tests_run++;
    if (tag_err !== 1'b1 || res_valid !== '0 || outstanding !== '0) begin
      tests_failed++;
      $display("[TB] FAIL spur_drop: got tag_err=%b valid=%b outstanding=%0d required 1 0000 0",
               tag_err, res_valid, outstanding);
    end
    tick();
    push_req(3, -32'sd9000, 32'd4);
    push_req(0, 32'd123456, -32'sd77);
    wait_drain("spur");
    tests_run++;
    if (tag_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL spur_sticky: got %b required 1", tag_err);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    tick();
    res_ready_r = '0;
    push_req(1, 32'd900, 32'd9);
    push_req(2, 32'd800, 32'd8);
    push_req(3, 32'd700, 32'd7);
    n = 0;
    while (outstanding !== OUT_W'(3) && n < 20) begin
      @(negedge clock);
      n++;
    end
    tests_run++;
    if (outstanding !== OUT_W'(3)) begin
      tests_failed++;
      $display("[TB] FAIL rmid_fill: got outstanding=%0d required 3", outstanding);
    end
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({res_valid, div_in_empty, div_out_rd_en, outstanding, tag_err, res_quotient} !== {4'b0, 1'b1, 1'b0, 3'b0, 1'b0, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL rmid_clear: got valid=%b in_empty=%b out_rd=%b outst=%0d tag_err=%b quot=%0d required 0000 1 0 0 0 0",
               res_valid, div_in_empty, div_out_rd_en, outstanding, tag_err, res_quotient);
    end
    clear_models();
    res_ready_r = '1;
    push_req(3, 32'd333, 32'd3);
    push_req(0, 32'd444, 32'd4);
    @(negedge clock);
    tests_run++;
    if (req_rd_en !== '0 || div_dividend !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rmid_hold: got rd_en=%b dvd=%0d required 0000 0", req_rd_en, div_dividend);
    end
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (req_rd_en !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL rmid_first: got %b required 0001", req_rd_en);
    end
    wait_drain("rmid");
  endtask

  initial begin
    refresh();
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_stall();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
